// File: rtl/sieve_engine.sv
// sieve_engine: sieve of Eratosthenes lookup coprocessor over [0, num].
//
// A run clears an internal 2^N x 1 bitmap (bit set = composite), strikes
// multiples of each prime from i*i upward, then counts the primes that
// survive. Once a run completes, the bitmap can be queried one value per
// cycle through a valid/ready port. All state changes on the falling edge
// of clk.
//
// Ports:
//   clk        clock, falling-edge active
//   rst        asynchronous, active-high reset
//   start      begin a run (sampled in IDLE only)
//   num        upper bound of the sieve, latched at start
//   busy       high while a run is in progress
//   done       one-cycle pulse when a run completes
//   valid      bitmap and prime_cnt describe the latched bound
//   prime_cnt  number of primes in [0, num]
//   q_valid    query request
//   q_k        value to test
//   q_ready    query can be accepted this cycle
//   r_valid    result strobe, one cycle after query acceptance
//   r_prime    1 when q_k is prime
module sieve_engine #(
  parameter int N     = 8,
  parameter int CNT_W = N + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     num,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [CNT_W-1:0] prime_cnt,
  input  logic             q_valid,
  input  logic [N-1:0]     q_k,
  output logic             q_ready,
  output logic             r_valid,
  output logic             r_prime
);

  localparam int DEPTH = 1 << N;

  localparam logic [N-1:0] ADDR_ONE = N'(1);
  localparam logic [N-1:0] ADDR_TWO = N'(2);
  localparam logic [N:0]   IDX_ONE  = (N + 1)'(1);
  localparam logic [N:0]   IDX_TWO  = (N + 1)'(2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    TEST  = 3'd2,
    MARK  = 3'd3,
    COUNT = 3'd4
  } state_t;

  state_t           state;
  logic [N-1:0]     reg_num;
  logic [N-1:0]     addr;
  logic [N:0]       i;
  logic [N:0]       j;
  logic [CNT_W-1:0] cnt;

  logic             mem [DEPTH];
  logic [N-1:0]     mem_addr;
  logic             mem_we;
  logic             mem_wd;
  logic             mem_rd;

  logic [2*N+1:0]   i_sq;
  logic [2*N+1:0]   num_wide;
  logic [N:0]       j_next;
  logic [N:0]       num_idx;
  logic [CNT_W-1:0] cnt_next;
  logic             query_accept;

  assign busy    = (state != IDLE);
  // start takes priority over a query arriving in the same cycle.
  assign q_ready = ~busy & ~start;
  assign query_accept = q_valid & q_ready;

  // Wide square and compare so i*i can never wrap past the bound.
  assign i_sq     = {{(N+1){1'b0}}, i} * {{(N+1){1'b0}}, i};
  assign num_wide = {{(N+2){1'b0}}, reg_num};
  assign num_idx  = {1'b0, reg_num};
  // One extra bit keeps the stride from wrapping back below the bound.
  assign j_next   = j + i;

  // Single bitmap port: the FSM state picks the one address in use.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    mem_addr = q_k;
    mem_we   = 1'b0;
    mem_wd   = 1'b0;
    case (state)
      CLEAR: begin
        mem_addr = addr;
        mem_we   = 1'b1;
        mem_wd   = (addr < ADDR_TWO);  // 0 and 1 are not prime
      end
      TEST:  mem_addr = i[N-1:0];     // i*i <= bound, so i fits in N bits
      MARK: begin
        mem_addr = j[N-1:0];          // j <= bound whenever MARK is entered
        mem_we   = 1'b1;
        mem_wd   = 1'b1;
      end
      COUNT: mem_addr = addr;
      default: mem_addr = q_k;
    endcase
  end

  assign mem_rd = mem[mem_addr];

  // Only addresses inside [2, bound] contribute to the count.
  assign cnt_next = (addr <= reg_num) ? cnt + {{(CNT_W-1){1'b0}}, ~mem_rd} : cnt;

  // NOTE: the bitmap has no reset; valid=0 masks stale contents until a full
  // run has re-cleared every address up to the bound.
  always_ff @(negedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wd;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      reg_num   <= '0;
      addr      <= '0;
      i         <= '0;
      j         <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      valid     <= 1'b0;
      prime_cnt <= '0;
      r_valid   <= 1'b0;
      r_prime   <= 1'b0;
    end else begin
      done    <= 1'b0;
      r_valid <= query_accept;
      r_prime <= query_accept & valid & (q_k <= reg_num) & ~mem_rd;

      case (state)
        IDLE: begin
          if (start) begin
            reg_num   <= num;
            valid     <= 1'b0;
            prime_cnt <= '0;
            addr      <= '0;
            state     <= CLEAR;
          end
        end

        CLEAR: begin
          if (addr == reg_num) begin
            i     <= IDX_TWO;
            state <= TEST;
          end else begin
            addr <= addr + ADDR_ONE;
          end
        end

        TEST: begin
          if (i_sq > num_wide) begin
            cnt   <= '0;
            addr  <= ADDR_TWO;
            state <= COUNT;
          end else if (mem_rd) begin
            i <= i + IDX_ONE;
          end else begin
            j     <= i_sq[N:0];
            state <= MARK;
          end
        end

        MARK: begin
          if (j_next > num_idx) begin
            i     <= i + IDX_ONE;
            state <= TEST;
          end else begin
            j <= j_next;
          end
        end

        COUNT: begin
          // addr >= bound also covers bounds below 2, where nothing is counted.
          if (addr >= reg_num) begin
            prime_cnt <= cnt_next;
            valid     <= 1'b1;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt  <= cnt_next;
            addr <= addr + ADDR_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sieve_engine.sv
// Self-checking bench for sieve_engine. The reference model decides
// primality by trial division and counts primes directly, independent of
// any sieve mechanics.
module tb_sieve_engine;

  localparam int N     = 8;
  localparam int CNT_W = N + 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [N-1:0]     num;
  logic             busy;
  logic             done;
  logic             valid;
  logic [CNT_W-1:0] prime_cnt;
  logic             q_valid;
  logic [N-1:0]     q_k;
  logic             q_ready;
  logic             r_valid;
  logic             r_prime;

  int checks = 0;
  int errors = 0;

  bit model_valid = 1'b0;
  int model_num   = 0;
  int qlist[$];

  sieve_engine #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num       (num),
    .busy      (busy),
    .done      (done),
    .valid     (valid),
    .prime_cnt (prime_cnt),
    .q_valid   (q_valid),
    .q_k       (q_k),
    .q_ready   (q_ready),
    .r_valid   (r_valid),
    .r_prime   (r_prime)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic bit is_prime(input int k);
    if (k < 2) return 1'b0;
    for (int d = 2; d * d <= k; d++)
      if (k % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int count_primes(input int n);
    int c = 0;
    for (int k = 0; k <= n; k++)
      if (is_prime(k)) c++;
    return c;
  endfunction

  function automatic bit expect_prime(input int k);
    return model_valid && (k <= model_num) && is_prime(k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // DUT updates on the falling edge; the bench samples and drives on the rising edge.
  task automatic step();
    @(posedge clk);
  endtask

  task automatic wait_done();
    int c = 0;
    while (done !== 1'b1 && c < 5000) begin
      step();
      c++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic finish_run(input int n);
    model_num   = n;
    model_valid = 1'b1;
    check("prime_cnt", 32'(prime_cnt), 32'(count_primes(n)));
    check("valid_at_done", {31'd0, valid}, 32'd1);
    step();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_sieve(input int n);
    start = 1'b1;
    num   = N'(n);
    step();
    start = 1'b0;
    model_valid = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("valid_cleared", {31'd0, valid}, 32'd0);
    wait_done();
    finish_run(n);
  endtask

  // Issues every value in qlist back-to-back, checking each result the cycle after.
  task automatic query_burst();
    foreach (qlist[idx]) begin
      q_valid = 1'b1;
      q_k     = N'(qlist[idx]);
      check("q_ready_idle", {31'd0, q_ready}, 32'd1);
      step();
      check($sformatf("r_valid_k%0d", qlist[idx]), {31'd0, r_valid}, 32'd1);
      check($sformatf("r_prime_k%0d", qlist[idx]), {31'd0, r_prime},
            {31'd0, expect_prime(qlist[idx])});
    end
    q_valid = 1'b0;
    step();
    check("r_valid_idle", {31'd0, r_valid}, 32'd0);
    qlist.delete();
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    num     = '0;
    q_valid = 1'b0;
    q_k     = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_prime_cnt", 32'(prime_cnt), 32'd0);
    check("rst_r_valid", {31'd0, r_valid}, 32'd0);
    check("rst_r_prime", {31'd0, r_prime}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Basic run to 30 and directed queries.
    run_sieve(30);
    qlist = '{29, 27, 2, 1, 0, 31};
    query_burst();

    // Full range with a query held across the whole run.
    start   = 1'b1;
    num     = 8'd255;
    q_valid = 1'b1;
    q_k     = 8'd3;
    step();
    start = 1'b0;
    model_valid = 1'b0;
    begin
      int c = 0;
      while (done !== 1'b1 && c < 5000) begin
        check("q_ready_busy", {31'd0, q_ready}, 32'd0);
        check("no_r_valid_busy", {31'd0, r_valid}, 32'd0);
        step();
        c++;
      end
    end
    check("done_seen_255", {31'd0, done}, 32'd1);
    model_num   = 255;
    model_valid = 1'b1;
    check("prime_cnt_255", 32'(prime_cnt), 32'd54);
    check("q_ready_at_done", {31'd0, q_ready}, 32'd1);
    step();
    check("held_query_r_valid", {31'd0, r_valid}, 32'd1);
    check("held_query_r_prime", {31'd0, r_prime}, 32'd1);
    q_valid = 1'b0;
    step();
    qlist = '{251, 253, 255, 254, 2};
    query_burst();
    for (int t = 0; t < 12; t++) qlist.push_back(int'($urandom_range(0, 255)));
    query_burst();

    // Degenerate bounds.
    run_sieve(1);
    qlist = '{1, 0, 2};
    query_burst();
    run_sieve(0);
    qlist = '{0, 1};
    query_burst();

    // Shrinking rerun must not report stale primes.
    run_sieve(100);
    check("prime_cnt_100", 32'(prime_cnt), 32'd25);
    run_sieve(10);
    check("prime_cnt_10", 32'(prime_cnt), 32'd4);
    qlist = '{13, 7, 10, 97};
    query_burst();

    // start pulsed mid-run is ignored.
    start = 1'b1;
    num   = 8'd100;
    step();
    start = 1'b0;
    model_valid = 1'b0;
    repeat (118) step();
    start = 1'b1;
    num   = 8'd10;
    step();
    start = 1'b0;
    wait_done();
    finish_run(100);
    qlist = '{97, 11, 99};
    query_burst();

    // Asynchronous reset mid-run.
    start = 1'b1;
    num   = 8'd200;
    step();
    start = 1'b0;
    repeat (230) step();
    #2 rst = 1'b1;
    #1;
    model_valid = 1'b0;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_valid", {31'd0, valid}, 32'd0);
    check("async_rst_prime_cnt", 32'(prime_cnt), 32'd0);
    check("async_rst_r_valid", {31'd0, r_valid}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    qlist = '{2, 3, 199};
    query_burst();
    run_sieve(200);
    check("prime_cnt_200", 32'(prime_cnt), 32'd46);
    qlist = '{199, 197, 200};
    query_burst();

    // Random bounds with random queries.
    for (int r = 0; r < 3; r++) begin
      run_sieve(int'($urandom_range(2, 255)));
      for (int t = 0; t < 8; t++) qlist.push_back(int'($urandom_range(0, 255)));
      query_burst();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
